id_stage: RTL

- Instruction-decode pipeline stage directly upstream of the 17-bit one-hot-controlled 64-bit ALU.
- Accepts a fetched instruction and PC, reads operands from the register file, and produces alu_ctrl, alu_sr1 and alu_sr2 plus writeback and branch side information.
- All outputs come from one output register behind a valid/ready handshake, with a flush from branch resolution.

---
 rtl/id_stage.sv | 305 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_stage
// Purpose  : Instruction-decode stage in front of the 17-bit one-hot ALU.
//            Reads register operands, decodes RV64I OP / OP-IMM / LUI / AUIPC /
//            BRANCH into alu_ctrl + operands, and registers everything behind
//            a valid/ready handshake with a branch-resolution flush.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            in_valid/in_ready        - fetch-side handshake
//            in_pc, in_inst           - fetched PC and instruction word
//            rs1_addr/rs2_addr        - combinational regfile read addresses
//            rs1_data/rs2_data        - same-cycle regfile read data
//            flush                    - kill held and incoming instruction
//            out_valid/out_ready      - ALU-side handshake
//            out_alu_ctrl/sr1/sr2     - one-hot op select and ALU operands
//            out_pc, out_rd, out_wen  - PC, destination, writeback enable
//            out_is_branch/br_off     - conditional branch flag and offset
//            out_word, out_illegal    - 32-bit W-op flag, unsupported encoding
// Options  : ID_RV64W_EN - enables OP-IMM-32 / OP-32 (W-op) decoding
// Revision : 1.0 - initial release
// ============================================================================
module id_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [16:0]     out_alu_ctrl,
  output logic [XLEN-1:0] out_alu_sr1,
  output logic [XLEN-1:0] out_alu_sr2,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_is_branch,
  output logic [XLEN-1:0] out_br_off,
  output logic            out_word,
  output logic            out_illegal
);

  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
`ifdef ID_RV64W_EN
  localparam logic [6:0] c_OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] c_OPC_OP32    = 7'b0111011;
`endif

  // One-hot ALU select bit positions
  localparam int c_ADD = 0, c_SUB = 1, c_SLT = 2, c_SLTU = 3, c_AND = 4,
                 c_XOR = 5, c_OR = 6, c_SLL = 7, c_SRL = 8, c_SRA = 9,
                 c_LUI = 10, c_BEQ = 11;

  // Instruction fields
  logic [6:0]      w_opcode, w_funct7;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm_i, w_imm_u, w_imm_b;
  logic            w_f7_zero, w_f7_alt;

  assign w_opcode  = in_inst[6:0];
  assign w_rd      = in_inst[11:7];
  assign w_funct3  = in_inst[14:12];
  assign w_funct7  = in_inst[31:25];
  assign w_f7_zero = (w_funct7 == 7'b0000000);
  assign w_f7_alt  = (w_funct7 == 7'b0100000);
  assign w_imm_i   = {{52{in_inst[31]}}, in_inst[31:20]};
  assign w_imm_u   = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
  assign w_imm_b   = {{51{in_inst[31]}}, in_inst[31], in_inst[7],
                      in_inst[30:25], in_inst[11:8], 1'b0};

  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];

  // Decoded next-state values
  logic [16:0]     ctrl_d;
  logic [XLEN-1:0] sr1_d, sr2_d, off_d;
  logic            br_d, ill_d, wen_d;
`ifdef ID_RV64W_EN
  logic            word_d, word_q;
`endif

  always_comb begin
    ctrl_d = '0;
    sr1_d  = '0;
    sr2_d  = '0;
    off_d  = '0;
    br_d   = 1'b0;
    ill_d  = 1'b0;
`ifdef ID_RV64W_EN
    word_d = 1'b0;
`endif
    case (w_opcode)
      c_OPC_OP: begin
        sr1_d = rs1_data;
        sr2_d = rs2_data;
        case (w_funct3)
          3'b000: begin
            if (w_f7_zero)     ctrl_d[c_ADD] = 1'b1;
            else if (w_f7_alt) ctrl_d[c_SUB] = 1'b1;
            else               ill_d = 1'b1;
          end
          3'b001: begin
            sr2_d = {58'b0, rs2_data[5:0]};
            if (w_f7_zero) ctrl_d[c_SLL] = 1'b1;
            else           ill_d = 1'b1;
          end
          3'b101: begin
            sr2_d = {58'b0, rs2_data[5:0]};
            if (w_f7_zero)     ctrl_d[c_SRL] = 1'b1;
            else if (w_f7_alt) ctrl_d[c_SRA] = 1'b1;
            else               ill_d = 1'b1;
          end
          default: begin
            // slt/sltu/xor/or/and accept only funct7 = 0
            if (!w_f7_zero) ill_d = 1'b1;
            else begin
              case (w_funct3)
                3'b010:  ctrl_d[c_SLT]  = 1'b1;
                3'b011:  ctrl_d[c_SLTU] = 1'b1;
                3'b100:  ctrl_d[c_XOR]  = 1'b1;
                3'b110:  ctrl_d[c_OR]   = 1'b1;
                default: ctrl_d[c_AND]  = 1'b1;
              endcase
            end
          end
        endcase
      end
      c_OPC_OPIMM: begin
        sr1_d = rs1_data;
        sr2_d = w_imm_i;
        case (w_funct3)
          3'b000: ctrl_d[c_ADD]  = 1'b1;
          3'b010: ctrl_d[c_SLT]  = 1'b1;
          3'b011: ctrl_d[c_SLTU] = 1'b1;
          3'b100: ctrl_d[c_XOR]  = 1'b1;
          3'b110: ctrl_d[c_OR]   = 1'b1;
          3'b111: ctrl_d[c_AND]  = 1'b1;
          3'b001: begin
            sr2_d = {58'b0, in_inst[25:20]};
            if (in_inst[31:26] == 6'b000000) ctrl_d[c_SLL] = 1'b1;
            else                             ill_d = 1'b1;
          end
          default: begin  // 101: SRLI / SRAI
            sr2_d = {58'b0, in_inst[25:20]};
            if (in_inst[31:26] == 6'b000000)      ctrl_d[c_SRL] = 1'b1;
            else if (in_inst[31:26] == 6'b010000) ctrl_d[c_SRA] = 1'b1;
            else                                  ill_d = 1'b1;
          end
        endcase
      end
      c_OPC_LUI: begin
        ctrl_d[c_LUI] = 1'b1;
        sr2_d         = w_imm_u;
      end
      c_OPC_AUIPC: begin
        ctrl_d[c_ADD] = 1'b1;
        sr1_d         = in_pc;
        sr2_d         = w_imm_u;
      end
      c_OPC_BRANCH: begin
        sr1_d = rs1_data;
        sr2_d = rs2_data;
        br_d  = 1'b1;
        off_d = w_imm_b;
        case (w_funct3)
          3'b010, 3'b011: ill_d = 1'b1;
          // 000,001 -> 11,12 ; 100..111 -> 13..16
          3'b000, 3'b001: ctrl_d[c_BEQ + int'(w_funct3[0])] = 1'b1;
          default:        ctrl_d[c_BEQ + int'(w_funct3) - 2] = 1'b1;
        endcase
      end
`ifdef ID_RV64W_EN
      c_OPC_OPIMM32: begin
        word_d = 1'b1;
        sr1_d  = rs1_data;
        sr2_d  = w_imm_i;
        case (w_funct3)
          3'b000: ctrl_d[c_ADD] = 1'b1;
          3'b001: begin
            sr2_d = {59'b0, in_inst[24:20]};
            if (w_f7_zero) ctrl_d[c_SLL] = 1'b1;
            else           ill_d = 1'b1;
          end
          3'b101: begin
            sr2_d = {59'b0, in_inst[24:20]};
            if (w_f7_zero) begin
              ctrl_d[c_SRL] = 1'b1;
              sr1_d         = {32'b0, rs1_data[31:0]};
            end else if (w_f7_alt) begin
              ctrl_d[c_SRA] = 1'b1;
              sr1_d         = {{32{rs1_data[31]}}, rs1_data[31:0]};
            end else ill_d = 1'b1;
          end
          default: ill_d = 1'b1;
        endcase
      end
      c_OPC_OP32: begin
        word_d = 1'b1;
        sr1_d  = rs1_data;
        sr2_d  = rs2_data;
        case (w_funct3)
          3'b000: begin
            if (w_f7_zero)     ctrl_d[c_ADD] = 1'b1;
            else if (w_f7_alt) ctrl_d[c_SUB] = 1'b1;
            else               ill_d = 1'b1;
          end
          3'b001: begin
            sr2_d = {59'b0, rs2_data[4:0]};
            if (w_f7_zero) ctrl_d[c_SLL] = 1'b1;
            else           ill_d = 1'b1;
          end
          3'b101: begin
            sr2_d = {59'b0, rs2_data[4:0]};
            if (w_f7_zero) begin
              ctrl_d[c_SRL] = 1'b1;
              sr1_d         = {32'b0, rs1_data[31:0]};
            end else if (w_f7_alt) begin
              ctrl_d[c_SRA] = 1'b1;
              sr1_d         = {{32{rs1_data[31]}}, rs1_data[31:0]};
            end else ill_d = 1'b1;
          end
          default: ill_d = 1'b1;
        endcase
      end
`endif
      default: ill_d = 1'b1;
    endcase

    // Illegal encodings carry no operation and no side effects
    if (ill_d) begin
      ctrl_d = '0;
      sr1_d  = '0;
      sr2_d  = '0;
      off_d  = '0;
      br_d   = 1'b0;
`ifdef ID_RV64W_EN
      word_d = 1'b0;
`endif
    end
    wen_d = !ill_d && !br_d && (w_rd != 5'd0);
  end

  // Output register and handshake
  logic w_load;
  assign in_ready = !out_valid | out_ready;
  assign w_load   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_alu_ctrl  <= '0;
      out_alu_sr1   <= '0;
      out_alu_sr2   <= '0;
      out_pc        <= '0;
      out_rd        <= '0;
      out_wen       <= 1'b0;
      out_is_branch <= 1'b0;
      out_br_off    <= '0;
      out_illegal   <= 1'b0;
`ifdef ID_RV64W_EN
      word_q        <= 1'b0;
`endif
    end else begin
      // Flush kills the slot; data registers may keep what was loaded
      if (flush)          out_valid <= 1'b0;
      else if (w_load)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;

      if (w_load) begin
        out_alu_ctrl  <= ctrl_d;
        out_alu_sr1   <= sr1_d;
        out_alu_sr2   <= sr2_d;
        out_pc        <= in_pc;
        out_rd        <= w_rd;
        out_wen       <= wen_d;
        out_is_branch <= br_d;
        out_br_off    <= off_d;
        out_illegal   <= ill_d;
`ifdef ID_RV64W_EN
        word_q        <= word_d;
`endif
      end
    end
  end

`ifdef ID_RV64W_EN
  assign out_word = word_q;
`else
  assign out_word = 1'b0;
`endif

endmodule
`default_nettype wire
